// File: rtl/pipelined_rca_addsub.sv
// rtl/pipelined_rca_addsub.sv - pipelined ripple-carry adder/subtractor
// One CHUNK-bit slice per stage; unconsumed operand bits ride along in skew registers.
module pipelined_rca_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * CHUNK;
    localparam int DONE = LO + CHUNK;
    localparam int REM  = WIDTH - DONE;

    logic                v_i;
    logic                c_i;
    logic [WIDTH-LO-1:0] a_rem_i;
    logic [WIDTH-LO-1:0] b_rem_i;
    logic [CHUNK:0]      slice;
    logic [DONE-1:0]     s_new;
    logic                v_d, v_q;
    logic                c_d, c_q;
    logic [DONE-1:0]     s_d, s_q;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1; b is inverted once here and never again.
      assign v_i     = in_valid;
      assign c_i     = sub | cin;
      assign a_rem_i = a;
      assign b_rem_i = sub ? ~b : b;
      assign s_new   = slice[CHUNK-1:0];
    end else begin : g_body
      assign v_i     = g_stage[k-1].v_q;
      assign c_i     = g_stage[k-1].c_q;
      assign a_rem_i = g_stage[k-1].g_skew.a_q;
      assign b_rem_i = g_stage[k-1].g_skew.b_q;
      assign s_new   = {slice[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign slice = {1'b0, a_rem_i[CHUNK-1:0]} + {1'b0, b_rem_i[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_i};

    // Bubbles advance the valid bit but leave data untouched, so the
    // final stage holds its last result while out_valid is low.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (adv) begin
        v_d = v_i;
        if (v_i) begin
          c_d = slice[CHUNK];
          s_d = s_new;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_d, a_q;
      logic [REM-1:0] b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv && v_i) begin
          a_d = a_rem_i[WIDTH-LO-1:CHUNK];
          b_d = b_rem_i[WIDTH-LO-1:CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
      always_comb begin
        ovf_d = ovf_q;
        if (adv && v_i) begin
          ovf_d = a_rem_i[CHUNK-1] ^ b_rem_i[CHUNK-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// tb/tb_pipelined_rca_addsub.sv - self-checking bench for pipelined_rca_addsub
module tb_pipelined_rca_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  always #5 clk = ~clk;

  pipelined_rca_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t        exp_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  logic        after_rst = 1'b0;
  logic        prev_valid, prev_ready, prev_cout, prev_ovf;
  logic [15:0] prev_sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [15:0] oa, input logic [15:0] ob,
                                 input logic oc, input logic os);
    res_t m;
    int sa, sb, r, u;
    sa = int'($signed(oa));
    sb = int'($signed(ob));
    if (os) begin
      r   = sa - sb;
      u   = int'(oa) - int'(ob);
      m.c = (oa >= ob);
    end else begin
      r   = sa + sb + int'(oc);
      u   = int'(oa) + int'(ob) + int'(oc);
      m.c = (u > 65535);
    end
    m.s = u[15:0];
    m.o = (r > 32767) || (r < -32768);
    return m;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        after_rst = 1'b0;
      end else if (prev_valid && !prev_ready) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", sum, prev_sum);
        chk("stall_cout", cout, prev_cout);
        chk("stall_ovf", ovf, prev_ovf);
      end else if (!prev_valid && !out_valid) begin
        chk("idle_sum", sum, prev_sum);
        chk("idle_cout", cout, prev_cout);
        chk("idle_ovf", ovf, prev_ovf);
      end
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          res_t e;
          e = exp_q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ovf   = ovf;
    end
  end

  task automatic send(input logic [15:0] oa, input logic [15:0] ob, input logic oc, input logic os);
    int w;
    in_valid = 1'b1;
    a = oa;
    b = ob;
    cin = oc;
    sub = os;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_stall", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                         input logic oc, input logic os,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = oa;
    b = ob;
    cin = oc;
    sub = os;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        done;
    logic [15:0] held_sum;
    logic        held_cout, held_ovf;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_in_ready", in_ready, 1);

    run_one("add_carry", 16'hFF00, 16'hFFFF, 1'b1, 1'b0, 16'hFF00, 1'b1, 1'b0);
    run_one("add_posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Back-to-back stream: eight results on eight consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 8; i++) begin
          chk("b2b_valid", out_valid, 1);
          @(negedge clk);
        end
      end
    join
    drain();

    // Three-cycle output stall in the middle of a stream.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          if (i == 0) begin
            held_sum  = sum;
            held_cout = cout;
            held_ovf  = ovf;
          end else begin
            chk("stall_held_sum", sum, held_sum);
            chk("stall_held_cout", cout, held_cout);
            chk("stall_held_ovf", ovf, held_ovf);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with bubbles and random backpressure.
    done = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
              @(posedge clk);
              #1;
            end
          end
          send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_result", out_valid, 0);
    end
    chk("midrst_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
